// File: rtl/escalonador_semaforos.sv
// escalonador_semaforos: round-robin scheduler for four vehicle approaches plus a pedestrian crossing.
// Green/yellow/clearance per grant; a latched pedestrian button wins the next decision point.
module escalonador_semaforos #(
    parameter logic [7:0] T_VERDE    = 8'd4,
    parameter logic [7:0] T_AMARELO  = 8'd2,
    parameter logic [7:0] T_LIMPEZA  = 8'd1,
    parameter logic [7:0] T_PEDESTRE = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        bt,
    output logic [11:0] luz,
    output logic        pedestre,
    output logic [1:0]  concede,
    output logic        ocioso
);
    typedef enum logic [2:0] {OCIOSO, VERDE, AMARELO, LIMPEZA, PEDESTRE} state_t;

    // A zero duration is illegal and behaves as one cycle.
    localparam logic [7:0] L_V = (T_VERDE    == 8'd0) ? 8'd0 : T_VERDE    - 8'd1;
    localparam logic [7:0] L_A = (T_AMARELO  == 8'd0) ? 8'd0 : T_AMARELO  - 8'd1;
    localparam logic [7:0] L_L = (T_LIMPEZA  == 8'd0) ? 8'd0 : T_LIMPEZA  - 8'd1;
    localparam logic [7:0] L_P = (T_PEDESTRE == 8'd0) ? 8'd0 : T_PEDESTRE - 8'd1;

    state_t      r_state, w_state;
    logic [7:0]  r_timer, w_timer;
    logic [1:0]  r_ptr, w_ptr, w_grant, w_idx;
    logic        r_pend, w_pend;
    logic        w_decide;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OCIOSO;
            r_timer <= 8'd0;
            r_ptr   <= 2'd3;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_timer <= w_timer;
            r_ptr   <= w_ptr;
            r_pend  <= w_pend;
        end
    end

    // Scan ptr+4 down to ptr+1 so the nearest requester after ptr is the last write.
    always_comb begin
        w_grant = r_ptr;
        w_idx   = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) w_grant = w_idx;
        end
    end

    assign w_decide = (r_state == OCIOSO) ||
                      (r_timer == 8'd0 && (r_state == LIMPEZA || r_state == PEDESTRE));

    always_comb begin
        w_state = r_state;
        w_timer = r_timer - 8'd1;
        w_ptr   = r_ptr;
        w_pend  = r_pend | (bt && r_state != PEDESTRE);
        if (r_timer == 8'd0 && r_state == VERDE) begin
            w_state = AMARELO;
            w_timer = L_A;
        end else if (r_timer == 8'd0 && r_state == AMARELO) begin
            w_state = LIMPEZA;
            w_timer = L_L;
        end else if (w_decide) begin
            if (r_state != PEDESTRE && (r_pend || bt)) begin
                w_state = PEDESTRE;
                w_timer = L_P;
                w_pend  = 1'b0;
            end else if (|req) begin
                w_state = VERDE;
                w_timer = L_V;
                w_ptr   = w_grant;
            end else begin
                w_state = OCIOSO;
                w_timer = 8'd0;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_luz
        assign luz[3*g +: 3] = (r_ptr == 2'(g) && r_state == VERDE)   ? 3'b001 :
                               (r_ptr == 2'(g) && r_state == AMARELO) ? 3'b010 : 3'b100;
    end

    assign pedestre = (r_state == PEDESTRE);
    assign ocioso   = (r_state == OCIOSO);
    assign concede  = r_ptr;
endmodule

// File: tb/tb_escalonador_semaforos.sv
// tb_escalonador_semaforos: directed checks of grant order, phase timing, pedestrian priority and async reset.
module tb_escalonador_semaforos;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic        bt  = 1'b0;
    logic [11:0] luz;
    logic        pedestre;
    logic [1:0]  concede;
    logic        ocioso;
    int total = 0;
    int bad   = 0;

    localparam logic [2:0] G = 3'b001, Y = 3'b010;

    escalonador_semaforos dut (
        .clk(clk), .rst(rst), .req(req), .bt(bt),
        .luz(luz), .pedestre(pedestre), .concede(concede), .ocioso(ocioso)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] lz(int a, logic [2:0] c);
        logic [11:0] v;
        v = 12'h924;
        v[3*a +: 3] = c;
        return v;
    endfunction

    task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_luz", luz, 12'h924);
        chk("rst_ped", 12'(pedestre), 12'd0);
        chk("rst_concede", 12'(concede), 12'd3);
        chk("rst_ocioso", 12'(ocioso), 12'd1);
        rst = 1'b1;
    endtask

    initial begin
        #2;
        // single requester cycles green/yellow/red/green
        req = 4'b0001;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                chk("s1_green", luz, lz(0, G));
                chk("s1_concede", 12'(concede), 12'd0);
            end
            for (int c = 0; c < 2; c++) begin
                step();
                chk("s1_yellow", luz, lz(0, Y));
            end
            step();
            chk("s1_clear", luz, 12'h924);
            chk("s1_clear_ocioso", 12'(ocioso), 12'd0);
        end
        // all requesting: 0,1,2,3,0 at 7-cycle spacing
        req = 4'b1111;
        do_reset();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("s2_luz", luz, lz(k % 4, G));
            chk("s2_concede", 12'(concede), 12'(k % 4));
            repeat (7) step();
        end
        // 1010 after serving 1 alternates 3,1; 0 and 2 never lit
        req = 4'b0010;
        do_reset();
        step();
        chk("s3_first", 12'(concede), 12'd1);
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 7; c++) begin
                step();
                chk("s3_l0_red", 12'(luz[2:0]), 12'h4);
                chk("s3_l2_red", 12'(luz[8:6]), 12'h4);
            end
            chk("s3_grant", luz, lz((k % 2 == 0) ? 3 : 1, G));
        end
        // bt during L2 green waits for clearance; bt during walk ignored
        req = 4'b0100;
        do_reset();
        step();
        chk("s4_green0", luz, lz(2, G));
        bt = 1'b1;
        step();
        bt = 1'b0;
        chk("s4_green1", luz, lz(2, G));
        repeat (2) step();
        chk("s4_green3", luz, lz(2, G));
        step();
        chk("s4_yellow", luz, lz(2, Y));
        repeat (2) step();
        chk("s4_clear", luz, 12'h924);
        chk("s4_clear_ped", 12'(pedestre), 12'd0);
        step();
        chk("s4_walk1", 12'(pedestre), 12'd1);
        chk("s4_walk1_luz", luz, 12'h924);
        bt = 1'b1;
        step();
        bt = 1'b0;
        chk("s4_walk2", 12'(pedestre), 12'd1);
        step();
        chk("s4_walk3", 12'(pedestre), 12'd1);
        step();
        chk("s4_after_walk", luz, lz(2, G));
        chk("s4_after_ped", 12'(pedestre), 12'd0);
        // bt alone from idle
        req = 4'b0000;
        do_reset();
        step();
        chk("s5_idle", 12'(ocioso), 12'd1);
        bt = 1'b1;
        step();
        bt = 1'b0;
        chk("s5_walk", 12'(pedestre), 12'd1);
        chk("s5_not_idle", 12'(ocioso), 12'd0);
        repeat (2) step();
        chk("s5_walk3", 12'(pedestre), 12'd1);
        step();
        chk("s5_back_idle", 12'(ocioso), 12'd1);
        chk("s5_back_ped", 12'(pedestre), 12'd0);
        // async reset mid-yellow on L1
        req = 4'b0010;
        do_reset();
        repeat (5) step();
        chk("s6_yellow", luz, lz(1, Y));
        rst = 1'b0;
        #1;
        chk("s6_async_luz", luz, 12'h924);
        chk("s6_async_ped", 12'(pedestre), 12'd0);
        chk("s6_async_concede", 12'(concede), 12'd3);
        #1;
        rst = 1'b1;
        step();
        chk("s6_regrant", luz, lz(1, G));
        chk("s6_regrant_c", 12'(concede), 12'd1);
        // pending press is lost across reset
        bt = 1'b1;
        step();
        bt = 1'b0;
        req = 4'b0001;
        do_reset();
        step();
        chk("s7_no_walk", 12'(pedestre), 12'd0);
        chk("s7_green0", luz, lz(0, G));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
